// File: rtl/hls_run_ctrl.sv
// hls_run_ctrl: initiator for the ap_ctrl_hs block-level handshake of an HLS core.
// It accepts one run command (invocation count and per-invocation timeout) and launches
// the core that many times, one invocation at a time. It counts the total cycles and
// returns a single status response.
//
// Ports
//   ap_clk, ap_rst_n     clock; asynchronous active-low reset, released synchronously inside
//   cmd_valid/cmd_ready  command handshake; cmd_runs = invocations, cmd_timeout = cycle limit
//                        per invocation (0 disables the limit)
//   ap_start             start request to the core; registered
//   ap_done/idle/ready   status inputs from the core
//   busy                 high whenever the controller is not idle
//   rsp_valid/rsp_ready  response handshake; the rsp_* fields stay stable while valid
//   rsp_status           0 = OK, 1 = TIMEOUT, 2 = ZERO_RUNS
//   rsp_runs_done        number of invocations that completed (ap_done seen)
//   rsp_cycles           cycles from the first ap_start through the last ap_done; saturating
module hls_run_ctrl #(
  parameter int unsigned RUNS_W = 8,
  parameter int unsigned TO_W   = 16,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [RUNS_W-1:0] cmd_runs,
  input  logic [TO_W-1:0]   cmd_timeout,
  output logic              ap_start,
  input  logic              ap_done,
  input  logic              ap_idle,
  input  logic              ap_ready,
  output logic              busy,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [RUNS_W-1:0] rsp_runs_done,
  output logic [CNT_W-1:0]  rsp_cycles
);

  localparam logic [1:0] StatOk      = 2'd0;
  localparam logic [1:0] StatTimeout = 2'd1;
  localparam logic [1:0] StatZero    = 2'd2;

  typedef enum logic [2:0] {StIdle, StWaitIdle, StStart, StRun, StResp} state_e;

  state_e            state_q, state_d;
  logic [1:0]        rst_sync_q;
  logic              rst_int_n;
  logic              ap_start_q;
  logic [RUNS_W-1:0] runs_q, runs_done_q, runs_done_inc;
  logic [TO_W-1:0]   timeout_q, to_cnt_q;
  logic [TO_W:0]     to_cnt_inc;
  logic [CNT_W-1:0]  cyc_q;
  logic [1:0]        status_q;
  logic              cmd_fire, active, inv_done, last_run, to_hit, counting;

  // The reset asserts asynchronously and is released on a clock edge.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_int_n = rst_sync_q[1];

  assign cmd_fire      = cmd_valid && cmd_ready;
  assign active        = (state_q == StStart) || (state_q == StRun);
  // In START, a done counts only together with ap_ready.
  assign inv_done      = ((state_q == StStart) && ap_ready && ap_done) ||
                         ((state_q == StRun) && ap_done);
  assign runs_done_inc = runs_done_q + RUNS_W'(1);
  assign last_run      = inv_done && (runs_done_inc == runs_q);
  // to_cnt_q is 0 in the first START cycle, so a limit of N trips in cycle N of the invocation.
  assign to_cnt_inc    = {1'b0, to_cnt_q} + (TO_W + 1)'(1);
  assign to_hit        = active && (timeout_q != '0) && (to_cnt_inc == {1'b0, timeout_q});
  // The total cycle count also runs through the WAIT_IDLE gaps after the first invocation.
  assign counting      = active || ((state_q == StWaitIdle) && (runs_done_q != '0));

  // State register
  always_ff @(posedge ap_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) state_d = (cmd_runs == '0) ? StResp : StWaitIdle;
      end
      StWaitIdle: begin
        if (ap_idle) state_d = StStart;
      end
      StStart, StRun: begin
        // A done in the same cycle as the timeout takes priority.
        if (inv_done) begin
          state_d = last_run ? StResp : StWaitIdle;
        end else if (to_hit) begin
          state_d = StResp;
        end else if ((state_q == StStart) && ap_ready) begin
          state_d = StRun;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    // Commands are held off until the internal reset is released, so none can be lost.
    cmd_ready = (state_q == StIdle) && rst_int_n;
    ap_start  = ap_start_q;
    busy      = (state_q != StIdle);
    rsp_valid = (state_q == StResp);
  end

  // Datapath registers
  always_ff @(posedge ap_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      ap_start_q  <= 1'b0;
      runs_q      <= '0;
      runs_done_q <= '0;
      timeout_q   <= '0;
      to_cnt_q    <= '0;
      cyc_q       <= '0;
      status_q    <= StatOk;
    end else begin
      ap_start_q <= (state_d == StStart);
      if (cmd_fire) begin
        runs_q      <= cmd_runs;
        timeout_q   <= cmd_timeout;
        runs_done_q <= '0;
        cyc_q       <= '0;
        if (cmd_runs == '0) status_q <= StatZero;
      end
      if ((state_d == StStart) && (state_q != StStart)) begin
        to_cnt_q <= '0;
      end else if (active) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      if (inv_done) runs_done_q <= runs_done_inc;
      if (last_run) begin
        status_q <= StatOk;
      end else if (to_hit && !inv_done) begin
        status_q <= StatTimeout;
      end
      if (counting && (cyc_q != '1)) cyc_q <= cyc_q + CNT_W'(1);
    end
  end

  assign rsp_status    = status_q;
  assign rsp_runs_done = runs_done_q;
  assign rsp_cycles    = cyc_q;

endmodule

// File: tb/tb_hls_run_ctrl.sv
// Bench for hls_run_ctrl. A behavioural core model answers ap_start with a planned ready
// latency, done latency and idle gap for each invocation. The expected response is worked
// out from that plan with plain arithmetic.
module tb_hls_run_ctrl;
  localparam int unsigned RUNS_W = 8;
  localparam int unsigned TO_W   = 16;
  localparam int unsigned CNT_W  = 32;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [RUNS_W-1:0] cmd_runs = '0;
  logic [TO_W-1:0]   cmd_timeout = '0;
  logic              ap_start;
  logic              ap_done, ap_idle, ap_ready;
  logic              busy, rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [1:0]        rsp_status;
  logic [RUNS_W-1:0] rsp_runs_done;
  logic [CNT_W-1:0]  rsp_cycles;

  hls_run_ctrl #(.RUNS_W(RUNS_W), .TO_W(TO_W), .CNT_W(CNT_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_runs(cmd_runs),
    .cmd_timeout(cmd_timeout), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .busy(busy), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_runs_done(rsp_runs_done),
    .rsp_cycles(rsp_cycles)
  );

  always #5 ap_clk = ~ap_clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Per-invocation plan: p_* is read by the core, q_* is staged by the stimulus.
  int unsigned p_rl[16], p_dl[16], p_gap[16];
  int unsigned q_rl[16], q_dl[16], q_gap[16];

  // Core model, evaluated on each falling edge.
  int unsigned c_phase = 0, c_cnt = 0, c_starts = 0, c_cur = 0, c_idle_bad = 0;
  logic        core_clr = 1'b0;

  task core_done();
    ap_done = 1'b1;
    if (p_gap[c_cur] == 0) c_phase = 0;
    else begin c_cnt = p_gap[c_cur]; c_phase = 3; end
  endtask

  task core_ready();
    ap_ready = 1'b1;
    if (p_dl[c_cur] == 0) core_done();
    else begin c_cnt = p_dl[c_cur]; c_phase = 2; end
  endtask

  initial begin
    ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;
    forever begin
      @(negedge ap_clk);
      ap_ready = 1'b0;
      ap_done  = 1'b0;
      if (core_clr) begin
        c_phase = 0;
        ap_idle = 1'b1;
      end else begin
        case (c_phase)
          0: begin
            if (ap_start) begin
              if (!ap_idle) c_idle_bad++;
              c_cur = c_starts % 16;
              c_starts++;
              if (p_rl[c_cur] == 0) core_ready();
              else begin c_cnt = p_rl[c_cur]; c_phase = 1; end
            end
            ap_idle = 1'b1;
          end
          1: begin
            if (!ap_start) c_phase = 0;
            else begin
              c_cnt--;
              if (c_cnt == 0) core_ready();
            end
          end
          2: begin
            ap_idle = 1'b0;
            c_cnt--;
            if (c_cnt == 0) core_done();
          end
          default: begin
            ap_idle = 1'b0;
            c_cnt--;
            if (c_cnt == 0) c_phase = 0;
          end
        endcase
      end
    end
  end

  task automatic wait_core_quiet(input string tag);
    int unsigned n = 0;
    while ((c_phase != 0 || !ap_idle) && n < 200) begin
      @(posedge ap_clk);
      n++;
    end
    check_val({tag, ".core_quiet"}, 64'(c_phase), 64'd0);
  endtask

  task automatic load_plan(input int unsigned runs, output int unsigned base);
    base = c_starts;
    for (int unsigned i = 0; i < runs; i++) begin
      p_rl[(base + i) % 16]  = q_rl[i];
      p_dl[(base + i) % 16]  = q_dl[i];
      p_gap[(base + i) % 16] = q_gap[i];
    end
  endtask

  task automatic run_cmd(input string tag, input int unsigned runs, input int unsigned tmo,
                         input int unsigned rsp_dly);
    int unsigned base, e_cyc, e_done, e_st, e_starts, waited, d;
    e_cyc = 0; e_done = 0;
    e_st = (runs == 0) ? 2 : 0;
    for (int unsigned i = 0; i < runs; i++) begin
      d = q_rl[i] + 1 + q_dl[i];
      if (tmo != 0 && d > tmo) begin
        e_cyc += tmo;
        e_st = 1;
        break;
      end
      e_cyc += d;
      e_done++;
      if (i + 1 < runs) e_cyc += q_gap[i] + 1;
    end
    e_starts = (e_st == 1) ? e_done + 1 : e_done;

    wait_core_quiet(tag);
    load_plan(runs, base);
    @(negedge ap_clk);
    check_val({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_runs = RUNS_W'(runs);
    cmd_timeout = TO_W'(tmo);
    @(negedge ap_clk);
    cmd_valid = 1'b0;
    waited = 0;
    while (!rsp_valid && waited < 3000) begin
      @(negedge ap_clk);
      waited++;
    end
    check_val({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
    if (!rsp_valid) return;
    if (runs == 0) check_val({tag, ".zero_latency"}, 64'(waited), 64'd0);
    check_val({tag, ".starts"}, 64'(c_starts - base), 64'(e_starts));
    check_val({tag, ".ap_start"}, 64'(ap_start), 64'd0);
    check_val({tag, ".busy"}, 64'(busy), 64'd1);
    for (int unsigned k = 0; k <= rsp_dly; k++) begin
      if (k > 0) @(negedge ap_clk);
      check_val({tag, ".hold_valid"}, 64'(rsp_valid), 64'd1);
      check_val({tag, ".cmd_ready_resp"}, 64'(cmd_ready), 64'd0);
      check_val({tag, ".status"}, 64'(rsp_status), 64'(e_st));
      check_val({tag, ".runs_done"}, 64'(rsp_runs_done), 64'(e_done));
      check_val({tag, ".cycles"}, 64'(rsp_cycles), 64'(e_cyc));
    end
    rsp_ready = 1'b1;
    @(negedge ap_clk);
    rsp_ready = 1'b0;
    check_val({tag, ".valid_drop"}, 64'(rsp_valid), 64'd0);
    check_val({tag, ".busy_drop"}, 64'(busy), 64'd0);
  endtask

  task automatic set_plan(input int unsigned i, input int unsigned rl, input int unsigned dl,
                          input int unsigned gap);
    q_rl[i] = rl; q_dl[i] = dl; q_gap[i] = gap;
  endtask

  task automatic reset_mid(input string tag, input int unsigned dly, input logic exp_start);
    int unsigned base;
    set_plan(0, 3, 30, 0);
    wait_core_quiet(tag);
    load_plan(1, base);
    @(negedge ap_clk);
    cmd_valid = 1'b1; cmd_runs = RUNS_W'(1); cmd_timeout = '0;
    @(negedge ap_clk);
    cmd_valid = 1'b0;
    repeat (dly) @(negedge ap_clk);
    check_val({tag, ".pre_busy"}, 64'(busy), 64'd1);
    check_val({tag, ".pre_start"}, 64'(ap_start), 64'(exp_start));
    ap_rst_n = 1'b0;
    #1;
    check_val({tag, ".rst_start"}, 64'(ap_start), 64'd0);
    check_val({tag, ".rst_busy"}, 64'(busy), 64'd0);
    check_val({tag, ".rst_valid"}, 64'(rsp_valid), 64'd0);
    @(negedge ap_clk);
    #1 core_clr = 1'b1;
    @(negedge ap_clk);
    @(negedge ap_clk);
    #1 core_clr = 1'b0;
    ap_rst_n = 1'b1;
    repeat (3) @(negedge ap_clk);
    check_val({tag, ".post_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check_val({tag, ".post_cycles"}, 64'(rsp_cycles), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned runs, tmo;
    repeat (3) @(negedge ap_clk);
    check_val("reset.ap_start", 64'(ap_start), 64'd0);
    check_val("reset.busy", 64'(busy), 64'd0);
    check_val("reset.rsp_valid", 64'(rsp_valid), 64'd0);
    ap_rst_n = 1'b1;
    repeat (3) @(negedge ap_clk);
    check_val("reset.cmd_ready", 64'(cmd_ready), 64'd1);
    check_val("reset.status", 64'(rsp_status), 64'd0);
    check_val("reset.runs_done", 64'(rsp_runs_done), 64'd0);
    check_val("reset.cycles", 64'(rsp_cycles), 64'd0);

    // Single run, ready latency 2, done 5 cycles after ready: 2 + 6 cycles.
    set_plan(0, 2, 5, 0);
    run_cmd("t1", 1, 0, 1);
    // Three runs with idle held low for 4 cycles after each done.
    for (int unsigned i = 0; i < 3; i++) set_plan(i, 1, 3, 4);
    run_cmd("t2", 3, 0, 0);
    // Single-cycle core: ready and done together with the first ap_start cycle.
    set_plan(0, 0, 0, 0); set_plan(1, 0, 0, 0);
    run_cmd("t3", 2, 0, 2);
    // Second invocation overruns a 10-cycle limit; its late done must be ignored.
    set_plan(0, 1, 2, 1); set_plan(1, 1, 20, 0);
    run_cmd("t4", 2, 10, 0);
    wait_core_quiet("t4.late");
    @(negedge ap_clk);
    check_val("t4.late_busy", 64'(busy), 64'd0);
    check_val("t4.late_valid", 64'(rsp_valid), 64'd0);
    check_val("t4.late_runs_done", 64'(rsp_runs_done), 64'd1);
    check_val("t4.late_status", 64'(rsp_status), 64'd1);
    // Zero runs with the response held for 7 cycles.
    run_cmd("t5", 0, 0, 7);
    // Done exactly on the timeout cycle completes; a timeout while still in START aborts.
    set_plan(0, 1, 4, 0);
    run_cmd("edge_done_eq_to", 1, 6, 0);
    set_plan(0, 5, 1, 0);
    run_cmd("edge_to_in_start", 1, 2, 1);
    // Reset while ap_start is high, then reset in RUN; each followed by a normal command.
    reset_mid("t6a", 2, 1'b1);
    set_plan(0, 1, 2, 0);
    run_cmd("t6a.after", 1, 0, 0);
    reset_mid("t6b", 8, 1'b0);
    set_plan(0, 0, 3, 1);
    run_cmd("t6b.after", 1, 0, 0);

    for (int unsigned n = 0; n < 25; n++) begin
      runs = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      tmo = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 14);
      for (int unsigned i = 0; i < runs; i++) begin
        set_plan(i, $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 4));
      end
      run_cmd($sformatf("rnd%0d", n), runs, tmo, $urandom_range(0, 3));
    end

    check_val("idle_at_start", 64'(c_idle_bad), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
